// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Single full-subtractor cell built from gate primitives, laid out like
// the full-adder cell of the adder datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic ab_x;
    logic a_n;
    logic ab_xn;
    logic brw_gen;
    logic brw_prop;

    xor u_xor_ab   (ab_x, a, b);
    xor u_xor_d    (diff, ab_x, bin);
    not u_not_a    (a_n, a);
    not u_not_x    (ab_xn, ab_x);
    // Borrow generated when a=0,b=1; propagated when a==b and a borrow came in.
    and u_and_gen  (brw_gen, a_n, b);
    and u_and_prop (brw_prop, ab_xn, bin);
    or  u_or_bout  (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin engine: LSB first, one bit per clock through a
// single full-subtractor cell, with a start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] r_sr_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;
    logic             cell_diff;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .bin  (br_reg),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == CNT_LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            r_sr_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        br_reg    <= bin;
                        cnt_reg   <= '0;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                    end
                end
                ST_RUN: begin
                    br_reg   <= cell_bout;
                    r_sr_reg <= {cell_diff, r_sr_reg[WIDTH-1:1]};
                    a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    cnt_reg  <= cnt_reg + 1'b1;
                end
                ST_DONE: begin
                    // r_sr already holds all WIDTH result bits here.
                    diff_reg <= r_sr_reg;
                    bout_reg <= br_reg;
                    ovf_reg  <= (a_msb_reg != b_msb_reg) &&
                                (r_sr_reg[WIDTH-1] != a_msb_reg);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result
// scoreboard drained one cycle after each done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic prev_done    = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned borrow from a 9-bit subtraction; ovf as signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.a    = ma;
        e.b    = mb;
        e.bin  = mbin;
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
        return e;
    endfunction

    // Results are valid in the cycle after done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_underflow: done with no expected result, diff=%02h", diff);
                end else begin
                    e = sb.pop_front();
                    if ({diff, bout, ovf} !== {e.diff, e.bout, e.ovf}) begin
                        tests_failed++;
                        $display("FAIL result %02h-%02h-%0d: got diff=%02h bout=%0b ovf=%0b, want diff=%02h bout=%0b ovf=%0b",
                                 e.a, e.b, e.bin, diff, bout, ovf, e.diff, e.bout, e.ovf);
                    end else begin
                        $display("[TB] op %02h-%02h-%0d -> diff=%02h bout=%0b ovf=%0b",
                                 e.a, e.b, e.bin, diff, bout, ovf);
                    end
                end
            end
            prev_done = done;
        end
    end

    // Issue one start pulse; returns at the negedge of the first RUN cycle.
    task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                            input bit push, input logic [W-1:0] ed, input logic eb,
                            input logic eo);
        exp_t e;
        @(negedge clk);
        a     = oa;
        b     = ob;
        bin   = obin;
        start = 1'b1;
        if (push) begin
            e.a = oa; e.b = ob; e.bin = obin; e.diff = ed; e.bout = eb; e.ovf = eo;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    // Bounded wait for done; cyc returns the cycle index (1 = first RUN cycle).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%0b done=%0b diff=%02h bout=%0b ovf=%0b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int  cyc;
        logic busy_ok;
        start_op(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 5) begin
                tests_run++;
                if (diff !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL diff_hold_in_run: got %02h, want 00", diff);
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc != 9) begin
            tests_failed++;
            $display("FAIL done_latency: done in cycle %0d, want 9", cyc);
        end
        tests_run++;
        if (!busy_ok || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_window: busy_ok=%0b busy_at_done=%0b, want 1 and 0", busy_ok, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width: done=%0b one cycle later, want 0", done);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        int cyc;
        start_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0); wait_done(cyc);
        start_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1); wait_done(cyc);
        start_op(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1); wait_done(cyc);
        start_op(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0); wait_done(cyc);
        start_op(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); wait_done(cyc);
    endtask

    task automatic test_abort();
        int cyc;
        int seen_done;
        // Start pulse in RUN cycle 3 with other operands must be ignored.
        start_op(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc != 9) begin
            tests_failed++;
            $display("FAIL abort_ignore_start: done in cycle %0d, want 9", cyc);
        end
        @(negedge clk);
        @(negedge clk);
        // Reset in RUN cycle 4 aborts the operation.
        start_op(8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset_outputs: got busy=%0b done=%0b diff=%02h bout=%0b ovf=%0b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        tests_run++;
        if (seen_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: saw %0d done pulses, want 0", seen_done);
        end
        start_op(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        wait_done(cyc);
    endtask

    task automatic test_back_to_back();
        logic [9:0] pattern;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            if (i % 10 == 0) rb = ra;
            a     = ra;
            b     = rb;
            bin   = rbin;
            start = 1'b1;
            sb.push_back(model(ra, rb, rbin));
            pattern = '0;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                pattern[j-1] = done;
                if (j < 10) begin
                    a   = W'($urandom);
                    b   = W'($urandom);
                    bin = 1'($urandom);
                end
            end
            tests_run++;
            if (pattern !== 10'b01_0000_0000) begin
                tests_failed++;
                $display("FAIL b2b_done_spacing op %0d: done pattern %b, want 0100000000", i, pattern);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d results never produced", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
